// File: rtl/branch_resolve_pkg.sv
// Shared branch-correction types: branch classes, predictor update and redirect
// payloads, plus the internal resolve-entry layout.
package branch_resolve_pkg;

    localparam int unsigned IDX_W = 6;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned PC_W  = 30;
    localparam int unsigned BT_W  = 3;

    typedef enum logic [BT_W-1:0] {
        BT_NONE = 3'd0,
        BT_COND = 3'd1,
        BT_JAL  = 3'd2,
        BT_JALR = 3'd3,
        BT_CALL = 3'd4,
        BT_RET  = 3'd5
    } br_type_e;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
        logic             taken;
        logic [BT_W-1:0]  btype;
    } bc_update_t;

    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] pc;
    } redirect_t;

    typedef struct packed {
        logic            valid;
        logic [BT_W-1:0] btype;
        logic            predict;
        logic            taken;
        logic [PC_W-1:0] nojpc;
        logic [PC_W-1:0] bpc;
    } br_entry_t;

    // Predictor index must not depend on BPC, so it is derived from the fall-through PC.
    function automatic logic [IDX_W-1:0] bc_index(input logic [PC_W-1:0] nojpc);
        return nojpc[IDX_W-1:0] - IDX_W'(1);
    endfunction

endpackage

// File: rtl/branch_resolve_sat_counter.sv
// Saturating event counter with synchronous clear.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// Resolves committed branches (ID- or MEM-resolved) and drives predictor
// training, fetch redirect and front-end flush back towards ID.
module branch_resolve
    import branch_resolve_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             ex_valid,
    input  logic [BT_W-1:0]  ex_branchType,
    input  logic             ex_predictTaken,
    input  logic             ex_idTaken,
    input  logic             ex_atMEM,
    input  logic [PC_W-1:0]  ex_NOJPC,
    input  logic [PC_W-1:0]  ex_BPC,
    input  logic             mem_taken,
    output logic             bc_valid,
    output logic [IDX_W-1:0] bc_idx,
    output logic             bc_taken,
    output logic [BT_W-1:0]  bc_type,
    output logic             redirect,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             flush,
    output logic [CNT_W-1:0] perf_branches,
    output logic [CNT_W-1:0] perf_mispredicts
);

    br_entry_t  pend_q, pend_d;
    br_entry_t  hold_q, hold_d;
    br_entry_t  issue, ex_res;
    bc_update_t bc_q, bc_d;
    redirect_t  rd_q, rd_d;
    logic       mem_src_q;
    logic       issue_mem;
    logic       mem_mis;
    logic       mispredict;
    logic       squash;
    logic       ex_seen;

    // Resolve mux: hold (oldest) > pending MEM > new EX; a MEM mispredict kills younger work.
    always_comb begin
        pend_d     = pend_q;
        hold_d     = hold_q;
        issue      = '0;
        issue_mem  = 1'b0;
        mem_mis    = 1'b0;
        mispredict = 1'b0;
        bc_d       = '0;
        rd_d       = '0;

        ex_res         = '0;
        ex_res.valid   = 1'b1;
        ex_res.btype   = ex_branchType;
        ex_res.predict = ex_predictTaken;
        ex_res.taken   = ex_idTaken;
        ex_res.nojpc   = ex_NOJPC;
        ex_res.bpc     = ex_BPC;

        // The instruction in EX while a MEM-sourced redirect is out is wrong-path.
        squash  = rd_q.valid && mem_src_q;
        ex_seen = ex_valid && (ex_branchType != BT_NONE) && !stall && !squash;

        if (!stall) begin
            if (hold_q.valid) begin
                issue        = hold_q;
                hold_d.valid = 1'b0;
            end else if (pend_q.valid) begin
                issue        = pend_q;
                issue.taken  = mem_taken;
                issue_mem    = 1'b1;
                pend_d.valid = 1'b0;
            end
        end

        mem_mis = issue_mem && (issue.taken ^ issue.predict);

        if (ex_seen && !mem_mis) begin
            if (ex_atMEM) begin
                pend_d = ex_res;
            end else if (issue.valid) begin
                hold_d = ex_res;
            end else begin
                issue = ex_res;
            end
        end

        mispredict = issue.valid && (issue.taken ^ issue.predict);

        if (issue.valid) begin
            bc_d.valid = 1'b1;
            bc_d.idx   = bc_index(issue.nojpc);
            bc_d.taken = issue.taken;
            bc_d.btype = issue.btype;
            rd_d.valid = mispredict;
            if (mispredict) begin
                rd_d.pc = issue.taken ? issue.bpc : issue.nojpc;
            end
        end
    end

    // Output/pending/hold registers; stall freezes pulses and payload in place.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q    <= '0;
            hold_q    <= '0;
            bc_q      <= '0;
            rd_q      <= '0;
            mem_src_q <= 1'b0;
        end else if (!stall) begin
            pend_q    <= pend_d;
            hold_q    <= hold_d;
            bc_q      <= bc_d;
            rd_q      <= rd_d;
            mem_src_q <= issue_mem;
        end
    end

    // Counting at issue time means a pulse held by stall is counted only once.
    sat_counter #(.W(CNT_W)) u_cnt_branches (
        .clk   (clk),
        .rst   (rst),
        .inc   (issue.valid),
        .clear (1'b0),
        .count (perf_branches)
    );

    sat_counter #(.W(CNT_W)) u_cnt_mispredicts (
        .clk   (clk),
        .rst   (rst),
        .inc   (mispredict),
        .clear (1'b0),
        .count (perf_mispredicts)
    );

    assign bc_valid    = bc_q.valid;
    assign bc_idx      = bc_q.idx;
    assign bc_taken    = bc_q.taken;
    assign bc_type     = bc_q.btype;
    assign redirect    = rd_q.valid;
    assign redirect_pc = rd_q.pc;
    assign flush       = rd_q.valid;

    // A parked EX result leaves no room for another EX branch (delay-slot rule).
    hold_no_overrun: assert property (@(posedge clk) disable iff (!rst) !(hold_q.valid && ex_seen));

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios plus random traffic
// against a queue-based reference model of branch resolution.
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        ex_valid;
    logic [2:0]  ex_branchType;
    logic        ex_predictTaken;
    logic        ex_idTaken;
    logic        ex_atMEM;
    logic [29:0] ex_NOJPC;
    logic [29:0] ex_BPC;
    logic        mem_taken;
    logic        bc_valid;
    logic [5:0]  bc_idx;
    logic        bc_taken;
    logic [2:0]  bc_type;
    logic        redirect;
    logic [29:0] redirect_pc;
    logic        flush;
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;

    branch_resolve dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .ex_valid         (ex_valid),
        .ex_branchType    (ex_branchType),
        .ex_predictTaken  (ex_predictTaken),
        .ex_idTaken       (ex_idTaken),
        .ex_atMEM         (ex_atMEM),
        .ex_NOJPC         (ex_NOJPC),
        .ex_BPC           (ex_BPC),
        .mem_taken        (mem_taken),
        .bc_valid         (bc_valid),
        .bc_idx           (bc_idx),
        .bc_taken         (bc_taken),
        .bc_type          (bc_type),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .flush            (flush),
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a resolution is a record; each cycle the oldest ready one issues.
    typedef struct packed {
        logic        mem;
        logic [2:0]  t;
        logic        pred;
        logic        taken;
        logic [29:0] nojpc;
        logic [29:0] bpc;
    } res_t;

    logic        m_bcv, m_taken, m_redir, m_mem;
    logic [5:0]  m_idx;
    logic [2:0]  m_type;
    logic [29:0] m_pc;
    logic [31:0] m_pb, m_pm;
    logic        pend_v;
    res_t        pend;
    res_t        parked[$];

    task automatic model_reset();
        m_bcv = 0; m_taken = 0; m_redir = 0; m_mem = 0;
        m_idx = '0; m_type = '0; m_pc = '0;
        m_pb = '0; m_pm = '0;
        pend_v = 0; pend = '0;
        parked.delete();
    endtask

    task automatic model_step();
        res_t ready[$];
        res_t r;
        res_t newp;
        bit   newp_v;
        bit   wrong_path;
        if (!rst || stall) return;
        wrong_path = m_redir && m_mem;
        ready  = parked;
        parked.delete();
        newp_v = 0;
        newp   = '0;
        if (pend_v) begin
            r = pend;
            r.taken = mem_taken;
            ready.push_back(r);
            pend_v = 0;
        end
        if (ex_valid && ex_branchType != 3'd0 && !wrong_path) begin
            r = '{mem: ex_atMEM, t: ex_branchType, pred: ex_predictTaken,
                  taken: ex_idTaken, nojpc: ex_NOJPC, bpc: ex_BPC};
            if (ex_atMEM) begin
                newp_v = 1; newp = r;
            end else begin
                ready.push_back(r);
            end
        end
        if (ready.size() > 0) begin
            r = ready.pop_front();
            m_bcv   = 1;
            m_idx   = 6'((r.nojpc % 64 + 63) % 64);
            m_taken = r.taken;
            m_type  = r.t;
            m_redir = (r.taken != r.pred);
            m_pc    = m_redir ? (r.taken ? r.bpc : r.nojpc) : 30'd0;
            m_mem   = r.mem;
            if (m_pb != 32'hffff_ffff) m_pb = m_pb + 1;
            if (m_redir && m_pm != 32'hffff_ffff) m_pm = m_pm + 1;
            if (r.mem && m_redir) begin
                ready.delete();
                newp_v = 0;
            end
        end else begin
            m_bcv = 0; m_redir = 0; m_mem = 0;
        end
        parked = ready;
        if (newp_v) begin
            pend_v = 1; pend = newp;
        end
    endtask

    task automatic compare_all();
        check("bc_valid", 64'(bc_valid), 64'(m_bcv));
        if (m_bcv) begin
            check("bc_idx", 64'(bc_idx), 64'(m_idx));
            check("bc_taken", 64'(bc_taken), 64'(m_taken));
            check("bc_type", 64'(bc_type), 64'(m_type));
        end
        check("redirect", 64'(redirect), 64'(m_redir));
        check("flush", 64'(flush), 64'(m_redir));
        if (m_redir) check("redirect_pc", 64'(redirect_pc), 64'(m_pc));
        check("perf_branches", 64'(perf_branches), 64'(m_pb));
        check("perf_mispredicts", 64'(perf_mispredicts), 64'(m_pm));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle();
        stall = 0; ex_valid = 0; ex_branchType = '0; ex_predictTaken = 0;
        ex_idTaken = 0; ex_atMEM = 0; ex_NOJPC = '0; ex_BPC = '0; mem_taken = 0;
    endtask

    task automatic drive_br(input logic [2:0] t, input logic pred, input logic idt,
                            input logic atm, input logic [29:0] nj, input logic [29:0] bp);
        ex_valid = 1; ex_branchType = t; ex_predictTaken = pred;
        ex_idTaken = idt; ex_atMEM = atm; ex_NOJPC = nj; ex_BPC = bp;
    endtask

    logic [31:0] pm_before;
    int          pulse_cycles;

    initial begin
        idle();
        model_reset();
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 1;

        // EX mispredict resolved in ID
        drive_br(3'd1, 0, 1, 0, 30'h40, 30'h100);
        step();
        check("d1_redirect", 64'(redirect), 64'd1);
        check("d1_pc", 64'(redirect_pc), 64'h100);
        check("d1_flush", 64'(flush), 64'd1);
        check("d1_taken", 64'(bc_taken), 64'd1);
        check("d1_idx", 64'(bc_idx), 64'h3f);
        check("d1_pm", 64'(perf_mispredicts), 64'd1);
        idle();
        step();

        // correct prediction
        drive_br(3'd1, 1, 1, 0, 30'h45, 30'h80);
        step();
        check("d2_bcv", 64'(bc_valid), 64'd1);
        check("d2_redirect", 64'(redirect), 64'd0);
        check("d2_pb", 64'(perf_branches), 64'd2);
        check("d2_pm", 64'(perf_mispredicts), 64'd1);
        idle();
        step();

        // MEM-resolved mispredict; EX during the redirect pulse is wrong-path
        drive_br(3'd1, 1, 1, 1, 30'h200, 30'h300);
        step();
        idle(); mem_taken = 0;
        step();
        check("d3_redirect", 64'(redirect), 64'd1);
        check("d3_pc", 64'(redirect_pc), 64'h200);
        drive_br(3'd1, 0, 1, 0, 30'h10, 30'h20);
        step();
        check("d3_squash_bcv", 64'(bc_valid), 64'd0);
        idle();
        step();

        // stall held across a redirect pulse
        pm_before = m_pm;
        drive_br(3'd3, 0, 1, 0, 30'h11, 30'h777);
        step();
        idle();
        pulse_cycles = (redirect === 1'b1) ? 1 : 0;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (redirect === 1'b1 && redirect_pc === 30'h777) pulse_cycles++;
        end
        stall = 0;
        step();
        check("d4_pulse_cycles", 64'(pulse_cycles), 64'd4);
        check("d4_pm_once", 64'(perf_mispredicts), 64'(pm_before + 32'd1));
        check("d4_dropped", 64'(redirect), 64'd0);

        // pending MEM correct and EX in the same cycle
        drive_br(3'd2, 1, 1, 1, 30'h50, 30'h60);
        step();
        drive_br(3'd5, 0, 0, 0, 30'h70, 30'h90); mem_taken = 1;
        step();
        check("d5_mem_type", 64'(bc_type), 64'd2);
        idle();
        step();
        check("d5_ex_bcv", 64'(bc_valid), 64'd1);
        check("d5_ex_type", 64'(bc_type), 64'd5);
        idle();
        step();

        // same with MEM mispredict: parked EX result discarded
        drive_br(3'd2, 1, 1, 1, 30'h50, 30'h60);
        step();
        drive_br(3'd5, 0, 0, 0, 30'h70, 30'h90); mem_taken = 0;
        step();
        check("d5m_redirect", 64'(redirect), 64'd1);
        idle();
        step();
        check("d5m_ex_gone", 64'(bc_valid), 64'd0);
        step();

        // asynchronous reset during a held redirect
        drive_br(3'd1, 1, 0, 0, 30'h33, 30'h44);
        step();
        idle(); stall = 1;
        step();
        #2;
        rst = 0;
        #1;
        model_reset();
        check("d6_bcv", 64'(bc_valid), 64'd0);
        check("d6_redirect", 64'(redirect), 64'd0);
        check("d6_flush", 64'(flush), 64'd0);
        check("d6_pb", 64'(perf_branches), 64'd0);
        check("d6_pm", 64'(perf_mispredicts), 64'd0);
        idle();
        #1;
        rst = 1;
        step();
        drive_br(3'd1, 0, 1, 0, 30'h40, 30'h100);
        step();
        check("d6_resume_pm", 64'(perf_mispredicts), 64'd1);
        idle();
        step();

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            stall           = ($urandom_range(0, 4) == 0);
            ex_valid        = ($urandom_range(0, 3) != 0);
            ex_branchType   = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            ex_predictTaken = 1'($urandom_range(0, 1));
            ex_idTaken      = 1'($urandom_range(0, 1));
            ex_atMEM        = 1'($urandom_range(0, 1));
            ex_NOJPC        = 30'($urandom);
            ex_BPC          = 30'($urandom);
            mem_taken       = 1'($urandom_range(0, 1));
            if (parked.size() != 0) ex_valid = 0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Resolves committed branches downstream of ID and produces the correction traffic that ID consumes: predictor-training updates, PC redirect on mispredict, and front-end flush. Sits beside EX/MEM and receives the branch-commit bundle latched by ID (prediction, ID-computed outcome, both candidate PCs, resolve-at-MEM flag). It closes the loop back into the branch predictor's correction port.

## Interface
- IDX_W, 6: predictor index width, taken from PC[IDX_W+1:2]
- CNT_W, 32: performance counter width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- stall  in  1  pipeline frozen
- ex_valid  in  1  EX holds a live instruction
- ex_branchType  in  3  branch class; 0 = not a branch
- ex_predictTaken  in  1  prediction made in ID
- ex_idTaken  in  1  outcome computed in ID from forwarded operands
- ex_atMEM  in  1  ID operands not final; resolve at MEM
- ex_NOJPC  in  30  fall-through PC[31:2]
- ex_BPC  in  30  branch-target PC[31:2]
- mem_taken  in  1  outcome recomputed at MEM with final operands
- bc_valid  out  1  predictor update strobe
- bc_idx  out  IDX_W  predictor index, BPC-independent: NOJPC[IDX_W+1:2] minus 1
- bc_taken  out  1  actual outcome
- bc_type  out  3  branch class
- redirect  out  1  mispredict, fetch from redirect_pc
- redirect_pc  out  30  corrected PC[31:2]
- flush  out  1  kill IF/ID (and EX when the source is MEM)
- perf_branches  out  CNT_W  resolved branches
- perf_mispredicts  out  CNT_W  redirects issued

## Operation
- Branch seen: ex_valid & ex_branchType!=0 & !stall.
- ex_atMEM=0: resolve now with taken=ex_idTaken.
- ex_atMEM=1: capture into pending register (one entry); resolve on next non-stall cycle with taken=mem_taken.
- Resolution: mispredict = taken ^ predictTaken; redirect_pc = taken ? BPC : NOJPC; bc_* always issued.
- Same-cycle pending(MEM) and new EX resolution: MEM is older and wins. EX result parks in a one-entry hold register and issues the next cycle. If MEM mispredicts, hold is discarded.
- Squash: in the cycle redirect is issued from a MEM-source resolution, ex inputs are ignored (wrong-path EX).
- Hold priority: a parked result issues before any new resolution; a new EX branch arriving while hold is full is illegal (delay-slot rule). Flag it with an assertion; hold is overwritten.
- Counters saturate at all-ones; perf_branches +1 per bc_valid, perf_mispredicts +1 per redirect, counted once even if held under stall.

## Timing
- All outputs registered; reset value of every output 0, pending/hold empty.
- EX-resolved branch at cycle N → bc_valid/redirect/flush high in N+1.
- MEM-resolved branch in EX at N → resolves at N+1 (if no stall) → outputs at N+2.
- Pulses last one cycle; if stall=1 while a pulse is high, the pulse and its payload hold until the first cycle with stall=0, then drop.
- stall freezes pending, hold, and capture; no new resolutions.
- rst low mid-operation: immediate clear of pulses, pending, hold, counters.

## Structure
- Shared package: branch-type constants (BT_NONE=0 …), a packed bc_update struct {valid, idx, taken, type}, and a redirect struct {valid, pc}, reused by the predictor and ID.
- Sub-module: sat_counter (CNT_W, inc, clear), instantiated twice.
- Remainder: pending register, hold register, output registers, resolve mux.

## Test plan
- EX branch, predict=0, idTaken=1, BPC=0x100, atMEM=0 at N → N+1: redirect=1, redirect_pc=0x100, flush=1, bc_taken=1; perf_mispredicts=1.
- Correct prediction (predict=1, idTaken=1) → N+1: bc_valid=1, redirect=0, flush=0; perf_branches=1, perf_mispredicts=0.
- atMEM=1, predict=1, mem_taken=0, NOJPC=0x200 → redirect at N+2 to 0x200; EX inputs at N+2 ignored.
- Stall asserted for 3 cycles during redirect pulse → redirect/redirect_pc stable for 4 cycles, perf_mispredicts increments once.
- Pending MEM correct + EX branch same cycle → MEM bc_valid at N+1, EX bc_valid at N+2; repeat with MEM mispredict → EX update never appears.
- Drive rst low during held redirect → all outputs 0 same cycle; counters 0; resumes cleanly after rst high.
